riscv_arbmux: RTL and testbench
===============================

# riscv_arbmux

Parametrised N-channel arbitrating multiplexer with a registered output stage. It supersedes the plain 4:1 select mux wherever several producers share one 64-bit consumer, for example writeback sources or requesters to the UART TX or CSR path. Instead of taking an external select, it picks one valid channel per cycle, either round-robin or fixed-priority. It handshakes with producers and consumer through valid/ready and holds the selected word in a one-entry output register.

## Interface
- WIDTH, 64, data width per channel
- CHANNELS, 4, number of input channels; legal range 2..16
- SEL_W, $clog2(CHANNELS), width of the grant index (derived, not overridden)

- i_riscv_arbmux_clk  in  1  clock; all state changes on the rising edge
- i_riscv_arbmux_rst_n  in  1  reset, asynchronous, active-low
- i_riscv_arbmux_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- i_riscv_arbmux_valid  in  CHANNELS  per-channel request
- i_riscv_arbmux_data  in  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- o_riscv_arbmux_ready  out  CHANNELS  per-channel accept; one-hot or zero
- o_riscv_arbmux_valid  out  1  output register holds a word
- o_riscv_arbmux_data  out  WIDTH  registered selected data
- o_riscv_arbmux_sel  out  SEL_W  index of the channel whose word is in the output register
- i_riscv_arbmux_ready  in  1  consumer accepts the output word

## Operation
- Load enable: load_en = !o_valid || i_ready.
- Arbitration is combinational and runs every cycle. The winner is computed from i_valid, the mode and the round-robin pointer rr_ptr (SEL_W bits).
  - Round-robin: search indices rr_ptr+1, rr_ptr+2, ... modulo CHANNELS; the first valid index wins.
  - Fixed priority: the lowest valid index wins; rr_ptr is ignored.
- o_ready[k] = load_en && (any i_valid) && (k == winner). All other bits are 0. A channel's transfer occurs when i_valid[k] && o_ready[k].
- On a transfer edge:
  - o_data <= channel data.
  - o_sel <= winner.
  - o_valid <= 1.
  - In round-robin mode only, rr_ptr <= winner.
- If load_en is true and no channel is valid, then o_valid <= 0 on that edge. o_data and o_sel hold their old values and are don't-care.
- If load_en is false (o_valid=1 and i_ready=0), the output register, rr_ptr and o_ready (all 0) hold. Producers must keep valid and data stable until accepted.
- Mode changes take effect in the same cycle's arbitration. rr_ptr keeps its value across a switch to fixed priority and back.
- Fairness: in round-robin mode with all channels continuously valid and the consumer always ready, grants cycle 0,1,...,CHANNELS-1,0,... Any continuously valid channel is granted within CHANNELS transfers.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - o_valid=0, o_data=0, o_sel=0.
  - rr_ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
  - o_ready=0 while reset is asserted.
- Latency: a word accepted at edge t appears on o_data/o_valid after edge t. That is one cycle from input transfer to output valid.
- Throughput: one word per cycle when the consumer holds i_ready=1. Simultaneous drain and load on the same edge is required. There are no bubbles.
- o_ready depends combinationally on i_ready, i_valid and mode. There is no combinational path from i_data to any output.
- Reset asserted mid-operation discards the held word. The first edge after deassertion behaves as from reset, with rr_ptr=CHANNELS-1.
- Wrap-around: when rr_ptr=CHANNELS-1, the search starts at 0. When CHANNELS is not a power of two, indices ≥ CHANNELS are never granted.

## Test plan
- Reset and idle: hold rst_n=0 with valid=4'b1111, then release with valid=0. Expect o_valid=0, o_data=0, o_sel=0 and ready=0 throughout.
- Round-robin sweep: set mode=0, valid=4'b1111 with data k=0x1000+k, and i_ready=1. Expect o_sel sequence 0,1,2,3,0, o_data 0x1000..0x1003, one word per cycle, and ready one-hot rotating.
- Fixed priority: set mode=1 and valid=4'b1010 for 4 cycles. Expect only channel 1 granted, ready=4'b0010 each cycle, and o_sel=1. Drop valid[1] and expect channel 3 granted next.
- Backpressure: deliver one word to the output, then hold i_ready=0 for 3 cycles with all channels valid. Expect ready=0 and o_data/o_sel/o_valid stable. Raise i_ready and expect drain and reload on the same edge.
- Pointer wrap and mode switch: in round-robin, grant channel 3 with valid=4'b1001, so the next winner is 0. Switch to mode=1 for 2 grants, then back to mode=0 with valid=4'b1111. Expect the next winner to be 0, since rr_ptr was unchanged at 3.
- Async reset mid-stream: assert rst_n=0 between edges while o_valid=1. Expect o_valid to drop immediately. After release with valid=4'b0100, expect the first grant to channel 2.

Source files
------------

// File: rtl/riscv_arbmux.sv
// N-channel round-robin / fixed-priority arbitrating mux into a one-entry output register.
// One-cycle latency from input transfer to output valid; ready is withheld while a held word is stalled.
module riscv_arbmux #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      i_riscv_arbmux_clk,
  input  logic                      i_riscv_arbmux_rst_n,
  input  logic                      i_riscv_arbmux_mode,
  input  logic [CHANNELS-1:0]       i_riscv_arbmux_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_riscv_arbmux_data,
  output logic [CHANNELS-1:0]       o_riscv_arbmux_ready,
  output logic                      o_riscv_arbmux_valid,
  output logic [WIDTH-1:0]          o_riscv_arbmux_data,
  output logic [SEL_W-1:0]          o_riscv_arbmux_sel,
  input  logic                      i_riscv_arbmux_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] winner;
  logic             any_valid;
  logic             load_en;
  logic [WIDTH-1:0] win_data;
  int               rr_idx;

  assign any_valid = |i_riscv_arbmux_valid;
  assign load_en   = !o_riscv_arbmux_valid || i_riscv_arbmux_ready;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    winner = '0;
    rr_idx = 0;
    if (i_riscv_arbmux_mode) begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (i_riscv_arbmux_valid[k]) winner = SEL_W'(k);
      end
    end else begin
      for (int i = CHANNELS; i >= 1; i--) begin
        rr_idx = (int'(rr_ptr) + i) % CHANNELS;
        if (i_riscv_arbmux_valid[rr_idx]) winner = SEL_W'(rr_idx);
      end
    end
  end

  // Ready is gated by reset so producers never see a grant while the register is cleared.
  always_comb begin
    o_riscv_arbmux_ready = '0;
    if (i_riscv_arbmux_rst_n && load_en && any_valid) o_riscv_arbmux_ready[winner] = 1'b1;
  end

  assign win_data = i_riscv_arbmux_data[int'(winner)*WIDTH +: WIDTH];

  always_ff @(posedge i_riscv_arbmux_clk or negedge i_riscv_arbmux_rst_n) begin
    if (!i_riscv_arbmux_rst_n) begin
      o_riscv_arbmux_valid <= 1'b0;
      o_riscv_arbmux_data  <= '0;
      o_riscv_arbmux_sel   <= '0;
      rr_ptr               <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      if (any_valid) begin
        o_riscv_arbmux_valid <= 1'b1;
        o_riscv_arbmux_data  <= win_data;
        o_riscv_arbmux_sel   <= winner;
        if (!i_riscv_arbmux_mode) rr_ptr <= winner;
      end else begin
        o_riscv_arbmux_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_arbmux.sv
// Directed bench for riscv_arbmux: stimulus pushes expected words, a monitor pops them on accept.
module tb_riscv_arbmux;

  localparam int WIDTH = 64;
  localparam int CH    = 4;
  localparam int SW    = 2;

  typedef struct packed {
    logic [SW-1:0]    sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic [CH-1:0]     valid;
  logic [CH*WIDTH-1:0] data;
  logic [CH-1:0]     ready;
  logic              o_valid;
  logic [WIDTH-1:0]  o_data;
  logic [SW-1:0]     o_sel;
  logic              c_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_arbmux #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .i_riscv_arbmux_clk   (clk),
    .i_riscv_arbmux_rst_n (rst_n),
    .i_riscv_arbmux_mode  (mode),
    .i_riscv_arbmux_valid (valid),
    .i_riscv_arbmux_data  (data),
    .o_riscv_arbmux_ready (ready),
    .o_riscv_arbmux_valid (o_valid),
    .o_riscv_arbmux_data  (o_data),
    .o_riscv_arbmux_sel   (o_sel),
    .i_riscv_arbmux_ready (c_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer-side monitor: every accepted output word must match the queue head.
  always @(negedge clk) begin
    if (rst_n && o_valid && c_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got sel %0d data 0x%0h expected none", o_sel, o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sel", 64'(o_sel), 64'(e.sel));
        check("out_data", o_data, e.data);
      end
    end
  end

  // One cycle: check ready at the negedge, optionally expect a grant, then advance past the edge.
  task automatic cyc(input logic [CH-1:0] exp_rdy, input bit push,
                     input logic [SW-1:0] sel, input logic [WIDTH-1:0] d);
    exp_t e;
    @(negedge clk);
    check("ready", 64'(ready), 64'(exp_rdy));
    if (push) begin
      e.sel  = sel;
      e.data = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    mode    = 1'b0;
    valid   = 4'b1111;
    c_ready = 1'b1;
    for (int k = 0; k < CH; k++) data[k*WIDTH +: WIDTH] = 64'h1000 + 64'(k);

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_sel", 64'(o_sel), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    valid = 4'b0000;
    rst_n = 1'b1;
    cyc(4'b0000, 0, 0, 0);
    check("idle_valid", 64'(o_valid), 64'd0);

    // Round-robin sweep
    valid = 4'b1111;
    cyc(4'b0001, 1, 0, 64'h1000);
    cyc(4'b0010, 1, 1, 64'h1001);
    cyc(4'b0100, 1, 2, 64'h1002);
    cyc(4'b1000, 1, 3, 64'h1003);
    cyc(4'b0001, 1, 0, 64'h1000);
    valid = 4'b0000;
    cyc(4'b0000, 0, 0, 0);
    check("drain_valid", 64'(o_valid), 64'd0);

    // Fixed priority
    mode  = 1'b1;
    valid = 4'b1010;
    repeat (4) cyc(4'b0010, 1, 1, 64'h1001);
    valid = 4'b1000;
    cyc(4'b1000, 1, 3, 64'h1003);
    valid = 4'b0000;
    cyc(4'b0000, 0, 0, 0);

    // Backpressure (rr_ptr still 0, so channel 1 wins)
    mode  = 1'b0;
    valid = 4'b1111;
    cyc(4'b0010, 1, 1, 64'h1001);
    c_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(ready), 64'd0);
      check("bp_valid", 64'(o_valid), 64'd1);
      check("bp_sel", 64'(o_sel), 64'd1);
      check("bp_data", o_data, 64'h1001);
      @(posedge clk); #1;
    end
    c_ready = 1'b1;
    cyc(4'b0100, 1, 2, 64'h1002);
    valid = 4'b0000;
    cyc(4'b0000, 0, 0, 0);

    // Pointer wrap and mode switch (rr_ptr is 2)
    valid = 4'b1001;
    cyc(4'b1000, 1, 3, 64'h1003);
    mode = 1'b1;
    cyc(4'b0001, 1, 0, 64'h1000);
    cyc(4'b0001, 1, 0, 64'h1000);
    mode  = 1'b0;
    valid = 4'b1111;
    cyc(4'b0001, 1, 0, 64'h1000);
    valid = 4'b0000;
    cyc(4'b0000, 0, 0, 0);

    // Async reset mid-stream: the held word is discarded, not delivered
    valid = 4'b1111;
    cyc(4'b0010, 0, 0, 0);
    c_ready = 1'b0;
    valid   = 4'b0000;
    check("pre_rst_valid", 64'(o_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(o_valid), 64'd0);
    check("async_data", o_data, 64'd0);
    check("async_sel", 64'(o_sel), 64'd0);
    @(posedge clk); #1;
    valid   = 4'b0100;
    c_ready = 1'b1;
    rst_n   = 1'b1;
    cyc(4'b0100, 1, 2, 64'h1002);
    valid = 4'b0000;
    cyc(4'b0000, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
